// File: rtl/rv_iommu_axi4_req_sched.sv
// IOMMU request scheduler: round-robin AR/AW arbitration into a single request
// register, 4-kiB boundary check hand-off, then routing to translation or error response.

package rv_iommu;
    localparam int unsigned XLEN = 64;
endpackage

package axi_pkg;
    typedef logic [1:0] burst_t;
    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
endpackage

// state  | meaning
// IDLE   | waiting for AR/AW valid; grants one channel and captures the request
// CHECK  | request presented to the boundary checker for exactly one cycle
// XLATE  | legal request offered to the translation front end until xlat_done_i
// ERR    | faulting request offered to the error responder until err_ready_i
module rv_iommu_axi4_req_sched #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          ar_valid_i,
    output logic                          ar_ready_o,
    input  logic [rv_iommu::XLEN-1:0]     ar_addr_i,
    input  axi_pkg::burst_t               ar_burst_i,
    input  axi_pkg::len_t                 ar_len_i,
    input  axi_pkg::size_t                ar_size_i,
    input  logic [ID_WIDTH-1:0]           ar_id_i,

    input  logic                          aw_valid_i,
    output logic                          aw_ready_o,
    input  logic [rv_iommu::XLEN-1:0]     aw_addr_i,
    input  axi_pkg::burst_t               aw_burst_i,
    input  axi_pkg::len_t                 aw_len_i,
    input  axi_pkg::size_t                aw_size_i,
    input  logic [ID_WIDTH-1:0]           aw_id_i,

    output logic                          bc_request_o,
    output logic [rv_iommu::XLEN-1:0]     bc_addr_o,
    output axi_pkg::burst_t               bc_burst_o,
    output axi_pkg::len_t                 bc_len_o,
    output axi_pkg::size_t                bc_size_o,
    input  logic                          bc_allow_i,
    input  logic                          bc_violation_i,

    output logic                          xlat_req_o,
    output logic                          xlat_rw_o,
    output logic [rv_iommu::XLEN-1:0]     xlat_addr_o,
    output logic [ID_WIDTH-1:0]           xlat_id_o,
    input  logic                          xlat_done_i,

    output logic                          err_valid_o,
    output logic                          err_rw_o,
    output logic [ID_WIDTH-1:0]           err_id_o,
    input  logic                          err_ready_i,

    output logic [CNT_W-1:0]              viol_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_XLATE,
        S_ERR
    } state_e;

    state_e                      state_q, state_d;
    logic                        last_w_q, last_w_d;
    logic [rv_iommu::XLEN-1:0]   addr_q, addr_d;
    axi_pkg::burst_t             burst_q, burst_d;
    axi_pkg::len_t               len_q, len_d;
    axi_pkg::size_t              size_q, size_d;
    logic [ID_WIDTH-1:0]         id_q, id_d;
    logic                        rw_q, rw_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic                        grant_w;
    logic                        grant_r;

    // On a tie the channel that was not granted last wins.
    always_comb begin
        grant_w = aw_valid_i & (~ar_valid_i | ~last_w_q);
        grant_r = ar_valid_i & ~grant_w;
    end

    always_comb begin
        state_d      = state_q;
        last_w_d     = last_w_q;
        addr_d       = addr_q;
        burst_d      = burst_q;
        len_d        = len_q;
        size_d       = size_q;
        id_d         = id_q;
        rw_d         = rw_q;
        cnt_d        = cnt_q;
        ar_ready_o   = 1'b0;
        aw_ready_o   = 1'b0;
        bc_request_o = 1'b0;
        xlat_req_o   = 1'b0;
        err_valid_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Never signal acceptance while the request register is being cleared.
                if (!rst_i && (grant_w || grant_r)) begin
                    ar_ready_o = grant_r;
                    aw_ready_o = grant_w;
                    last_w_d   = grant_w;
                    rw_d       = grant_w;
                    state_d    = S_CHECK;
                    if (grant_w) begin
                        addr_d  = aw_addr_i;
                        burst_d = aw_burst_i;
                        len_d   = aw_len_i;
                        size_d  = aw_size_i;
                        id_d    = aw_id_i;
                    end else begin
                        addr_d  = ar_addr_i;
                        burst_d = ar_burst_i;
                        len_d   = ar_len_i;
                        size_d  = ar_size_i;
                        id_d    = ar_id_i;
                    end
                end
            end

            S_CHECK: begin
                bc_request_o = 1'b1;
                // A checker asserting both verdicts is treated as legal.
                if (bc_allow_i) begin
                    state_d = S_XLATE;
                end else if (bc_violation_i) begin
                    state_d = S_ERR;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = S_ERR;
                end
            end

            S_XLATE: begin
                xlat_req_o = 1'b1;
                if (xlat_done_i) begin
                    state_d = S_IDLE;
                end
            end

            S_ERR: begin
                err_valid_o = 1'b1;
                if (err_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            last_w_q <= 1'b1;
            addr_q   <= '0;
            burst_q  <= '0;
            len_q    <= '0;
            size_q   <= '0;
            id_q     <= '0;
            rw_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_w_q <= last_w_d;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            len_q    <= len_d;
            size_q   <= size_d;
            id_q     <= id_d;
            rw_q     <= rw_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bc_addr_o   = addr_q;
    assign bc_burst_o  = burst_q;
    assign bc_len_o    = len_q;
    assign bc_size_o   = size_q;

    assign xlat_rw_o   = rw_q;
    assign xlat_addr_o = addr_q;
    assign xlat_id_o   = id_q;

    assign err_rw_o    = rw_q;
    assign err_id_o    = id_q;

    assign viol_cnt_o  = cnt_q;

endmodule

// File: tb/tb_rv_iommu_axi4_req_sched.sv
// Bench for rv_iommu_axi4_req_sched: vector table plus corner sequences, with a
// scoreboard queue matched against each new xlat/err output.

module tb_rv_iommu_axi4_req_sched;

    localparam int ID_W  = 4;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              ar_valid, aw_valid, ar_ready_o, aw_ready_o;
    logic [63:0]       ar_addr, aw_addr;
    logic [1:0]        ar_burst, aw_burst;
    logic [7:0]        ar_len, aw_len;
    logic [2:0]        ar_size, aw_size;
    logic [ID_W-1:0]   ar_id, aw_id;
    logic              bc_request_o, bc_allow, bc_viol;
    logic [63:0]       bc_addr_o;
    logic [1:0]        bc_burst_o;
    logic [7:0]        bc_len_o;
    logic [2:0]        bc_size_o;
    logic              xlat_req_o, xlat_rw_o, xlat_done;
    logic [63:0]       xlat_addr_o;
    logic [ID_W-1:0]   xlat_id_o;
    logic              err_valid_o, err_rw_o, err_ready;
    logic [ID_W-1:0]   err_id_o;
    logic [CNT_W-1:0]  viol_cnt_o;
    logic              force_both;

    rv_iommu_axi4_req_sched #(.ID_WIDTH(ID_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr),
        .ar_burst_i(ar_burst), .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_id_i(ar_id),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr),
        .aw_burst_i(aw_burst), .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_id_i(aw_id),
        .bc_request_o(bc_request_o), .bc_addr_o(bc_addr_o), .bc_burst_o(bc_burst_o),
        .bc_len_o(bc_len_o), .bc_size_o(bc_size_o),
        .bc_allow_i(bc_allow), .bc_violation_i(bc_viol),
        .xlat_req_o(xlat_req_o), .xlat_rw_o(xlat_rw_o), .xlat_addr_o(xlat_addr_o),
        .xlat_id_o(xlat_id_o), .xlat_done_i(xlat_done),
        .err_valid_o(err_valid_o), .err_rw_o(err_rw_o), .err_id_o(err_id_o),
        .err_ready_i(err_ready), .viol_cnt_o(viol_cnt_o)
    );

    // Reference 4-kiB boundary checker driving the verdict inputs.
    logic [16:0] beats, span;
    always_comb begin
        beats    = {9'd0, bc_len_o} + 17'd1;
        span     = {5'd0, bc_addr_o[11:0]} + (beats << bc_size_o);
        bc_allow = 1'b0;
        bc_viol  = 1'b0;
        case (bc_burst_o)
            2'b00, 2'b10: bc_allow = 1'b1;
            2'b01: begin
                if (span > 17'h1000) bc_viol = 1'b1;
                else                 bc_allow = 1'b1;
            end
            default: ;
        endcase
        if (force_both) begin
            bc_allow = 1'b1;
            bc_viol  = 1'b1;
        end
    end

    typedef struct {
        bit              w;
        logic [63:0]     addr;
        logic [1:0]      burst;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [ID_W-1:0] id;
        bit              err;
        bit              inc;
    } vec_t;

    typedef struct {
        bit              err;
        bit              rw;
        logic [63:0]     addr;
        logic [ID_W-1:0] id;
        int              cyc;
        bit              inc;
    } exp_t;

    exp_t            sb[$];
    vec_t            vecs[7];
    int              n_chk, n_pass, cyc, t_acc;
    bit              was_act;
    logic [127:0]    held;
    logic [CNT_W-1:0] cnt_exp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [127:0] snap();
        return 128'({err_valid_o, xlat_req_o, err_rw_o, err_id_o, xlat_rw_o, xlat_id_o, xlat_addr_o});
    endfunction

    task automatic mon();
        exp_t e;
        bit   act;
        act = xlat_req_o || err_valid_o;
        if (act && !was_act) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 128'(act), 128'(0));
            end else begin
                e = sb.pop_front();
                if (e.inc && cnt_exp != {CNT_W{1'b1}}) cnt_exp = cnt_exp + 1'b1;
                chk("kind", 128'({err_valid_o, xlat_req_o}), e.err ? 128'(2) : 128'(1));
                chk("rw", 128'(e.err ? err_rw_o : xlat_rw_o), 128'(e.rw));
                chk("id", 128'(e.err ? err_id_o : xlat_id_o), 128'(e.id));
                if (!e.err) chk("addr", 128'(xlat_addr_o), 128'(e.addr));
                chk("latency", 128'(cyc), 128'(e.cyc));
                chk("viol_cnt", 128'(viol_cnt_o), 128'(cnt_exp));
                held = snap();
            end
        end else if (act && was_act) begin
            chk("hold_payload", snap(), held);
            if (ar_valid || aw_valid) chk("ready_backpressure", 128'({aw_ready_o, ar_ready_o}), 128'(0));
        end
        was_act = act;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mon();
    endtask

    task automatic drive(input vec_t v);
        if (v.w) begin
            aw_addr = v.addr; aw_burst = v.burst; aw_len = v.len;
            aw_size = v.size; aw_id = v.id; aw_valid = 1'b1;
        end else begin
            ar_addr = v.addr; ar_burst = v.burst; ar_len = v.len;
            ar_size = v.size; ar_id = v.id; ar_valid = 1'b1;
        end
    endtask

    task automatic accept(input bit w, input bit exp_err, input bit exp_inc, input bit drop);
        exp_t e;
        int   n;
        n = 0;
        #1;
        while (!(ar_ready_o || aw_ready_o) && n < 20) begin
            step();
            #1;
            n++;
        end
        chk("grant_channel", 128'({aw_ready_o, ar_ready_o}), w ? 128'(2) : 128'(1));
        t_acc  = cyc;
        e.err  = exp_err;
        e.rw   = w;
        e.addr = w ? aw_addr : ar_addr;
        e.id   = w ? aw_id : ar_id;
        e.cyc  = cyc + 2;
        e.inc  = exp_inc;
        sb.push_back(e);
        step();
        if (drop) begin
            if (w) aw_valid = 1'b0;
            else   ar_valid = 1'b0;
        end
        chk("bc_request", 128'(bc_request_o), 128'(1));
        chk("bc_addr", 128'(bc_addr_o), 128'(e.addr));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || xlat_req_o || err_valid_o) && n < 40) begin
            step();
            n++;
        end
        chk("drain", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        vec_t v;
        int   t0, tr;
        n_chk = 0; n_pass = 0; cyc = 0; was_act = 0; cnt_exp = '0; held = '0;
        rst = 1'b1; force_both = 1'b0; xlat_done = 1'b1; err_ready = 1'b1;
        ar_valid = 0; aw_valid = 0;
        ar_addr = 64'h10; ar_burst = 2'b01; ar_len = 0; ar_size = 2; ar_id = 4'h1;
        aw_addr = 64'h20; aw_burst = 2'b01; aw_len = 0; aw_size = 2; aw_id = 4'h8;

        vecs[0] = '{w:0, addr:64'h0FF0,      burst:2'b01, len:8'd0,  size:3'd3, id:4'd5, err:0, inc:0};
        vecs[1] = '{w:1, addr:64'h0FF8,      burst:2'b01, len:8'd1,  size:3'd3, id:4'd2, err:1, inc:1};
        vecs[2] = '{w:0, addr:64'h0100,      burst:2'b11, len:8'd0,  size:3'd2, id:4'd7, err:1, inc:0};
        vecs[3] = '{w:1, addr:64'h0FFC,      burst:2'b00, len:8'd15, size:3'd2, id:4'd9, err:0, inc:0};
        vecs[4] = '{w:0, addr:64'h1000_0F00, burst:2'b01, len:8'd15, size:3'd4, id:4'd3, err:0, inc:0};
        vecs[5] = '{w:0, addr:64'h0F01,      burst:2'b01, len:8'd15, size:3'd4, id:4'd4, err:1, inc:1};
        vecs[6] = '{w:1, addr:64'h0FF0,      burst:2'b10, len:8'd3,  size:3'd2, id:4'd1, err:0, inc:0};

        // Reset with both channels already requesting.
        ar_valid = 1; aw_valid = 1;
        step(); step();
        #1;
        chk("rst_ready", 128'({aw_ready_o, ar_ready_o}), 128'(0));
        chk("rst_strobes", 128'({bc_request_o, xlat_req_o, err_valid_o}), 128'(0));
        chk("rst_payload", 128'({xlat_addr_o, xlat_id_o, bc_burst_o, bc_len_o, bc_size_o, err_id_o, err_rw_o}), 128'(0));
        chk("rst_cnt", 128'(viol_cnt_o), 128'(0));
        rst = 1'b0;

        // Continuous tie: AR, AW, AR, AW at three-cycle spacing.
        t0 = 0;
        for (int k = 0; k < 4; k++) begin
            accept(k[0], 0, 0, 0);
            if (k == 0) t0 = t_acc;
            else chk("rr_spacing", 128'(t_acc), 128'(t0 + 3 * k));
        end
        ar_valid = 0; aw_valid = 0;
        drain();

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i]);
            accept(vecs[i].w, vecs[i].err, vecs[i].inc, 1);
            drain();
        end

        // Error held off for ten cycles while a read waits.
        err_ready = 1'b0;
        v = '{w:1, addr:64'hFFFC, burst:2'b01, len:8'd0, size:3'd3, id:4'd6, err:1, inc:1};
        drive(v);
        accept(1, 1, 1, 1);
        step();
        v = '{w:0, addr:64'h40, burst:2'b01, len:8'd0, size:3'd2, id:4'hA, err:0, inc:0};
        drive(v);
        repeat (10) step();
        chk("err_still_valid", 128'(err_valid_o), 128'(1));
        tr = cyc;
        err_ready = 1'b1;
        accept(0, 0, 0, 1);
        chk("release_to_idle", 128'(t_acc), 128'(tr + 1));
        drain();

        // Checker asserting both verdicts: allow wins, no count.
        force_both = 1'b1;
        v = '{w:0, addr:64'h0FF8, burst:2'b01, len:8'd1, size:3'd3, id:4'hC, err:0, inc:0};
        drive(v);
        accept(0, 0, 0, 1);
        drain();
        force_both = 1'b0;

        // Reset while a translation is outstanding.
        xlat_done = 1'b0;
        v = '{w:0, addr:64'h200, burst:2'b01, len:8'd0, size:3'd2, id:4'hD, err:0, inc:0};
        drive(v);
        accept(0, 0, 0, 1);
        step();
        step();
        rst = 1'b1;
        step();
        #1;
        chk("midrst_strobes", 128'({ar_ready_o, aw_ready_o, bc_request_o, xlat_req_o, err_valid_o}), 128'(0));
        chk("midrst_payload", 128'({xlat_addr_o, xlat_id_o, xlat_rw_o}), 128'(0));
        chk("midrst_cnt", 128'(viol_cnt_o), 128'(0));
        cnt_exp = '0;
        rst = 1'b0;
        xlat_done = 1'b1;
        repeat (3) step();
        chk("midrst_no_pulse", 128'({xlat_req_o, err_valid_o}), 128'(0));
        drain();

        // Five violations saturate a two-bit counter.
        for (int i = 0; i < 5; i++) begin
            v = '{w:1, addr:64'h0FF8, burst:2'b01, len:8'd1, size:3'd3, id:4'(i), err:1, inc:1};
            drive(v);
            accept(1, 1, 1, 1);
            drain();
        end
        chk("sat_cnt", 128'(viol_cnt_o), 128'(3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
